// File: rtl/rns2bin_32_31_21_5.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rns2bin_32_31_21_5
// Purpose  : Residue-to-binary converter for the moduli set {32, 31, 21, 5}
//            (dynamic range 0..104159). It uses mixed-radix conversion:
//              X = v1 + 32*v2 + 992*v3 + 20832*v4
//            One digit is produced per state (V2, V3, V4), the weighted sum
//            is registered in SUM, and the result is held in OUT until the
//            consumer accepts it.
// Ports    : clk        - rising-edge clock
//            reset      - asynchronous active-low reset
//            in_valid   - residue tuple valid
//            in_ready   - high only in IDLE; a tuple transfers on
//                         in_valid && in_ready
//            in_mod_1..4- residues mod 32, 31, 21 and 5
//            out_valid  - out_bin / out_err valid (held until out_ready)
//            out_ready  - consumer accepts the result
//            out_bin    - reconstructed value, DYN_SIZE+1 bits
//            out_err    - at least one residue was out of range
// Revision : 1.0 - initial release
// ============================================================================
module rns2bin_32_31_21_5 #(
  parameter int DYN_SIZE = 16,
  parameter int MAX_MOD  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MAX_MOD-1:0]  in_mod_1,
  input  logic [MAX_MOD-1:0]  in_mod_2,
  input  logic [MAX_MOD-1:0]  in_mod_3,
  input  logic [MAX_MOD-1:0]  in_mod_4,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DYN_SIZE:0]   out_bin,
  output logic                out_err
);

  // Working width for every intermediate. The largest operand is the full
  // weighted sum (at most 31+32*31+992*31+20832*7 < 2^18), so 21 bits never
  // truncates, even for the garbage digits of an out-of-range tuple.
  localparam int CALC_W = 21;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    V2   = 3'd1,
    V3   = 3'd2,
    V4   = 3'd3,
    SUM  = 3'd4,
    OUT  = 3'd5
  } state_t;

  state_t               state;
  logic [MAX_MOD-1:0]   x2;
  logic [MAX_MOD-1:0]   x3;
  logic [MAX_MOD-1:0]   x4;
  logic [MAX_MOD-1:0]   v1;
  logic [4:0]           v2;
  logic [4:0]           v3;
  logic [2:0]           v4;
  logic                 err_flag;

  logic [CALC_W-1:0]    part1;
  logic [CALC_W-1:0]    part2;
  logic [CALC_W-1:0]    total;
  logic [4:0]           v2_next;
  logic [4:0]           v3_next;
  logic [2:0]           v4_next;
  logic [DYN_SIZE:0]    bin_next;
  logic                 err_in;

  // Reduce a modulo m by restoring subtraction of m<<k, k = 14..0.
  // Correct for any a < m<<15, which covers every call below.
  function automatic logic [CALC_W-1:0] mod_reduce(input logic [CALC_W-1:0] a,
                                                   input logic [5:0]        m);
    logic [CALC_W-1:0] r;
    logic [CALC_W-1:0] mw;
    r  = a;
    mw = CALC_W'(m);
    for (int k = 14; k >= 0; k--) begin
      if (r >= (mw << k)) begin
        r = r - (mw << k);
      end
    end
    return r;
  endfunction

  // (a - b) mod m for b already reduced: add the modulus back when the
  // difference would go negative.
  function automatic logic [CALC_W-1:0] mod_sub(input logic [CALC_W-1:0] a,
                                                input logic [CALC_W-1:0] b,
                                                input logic [5:0]        m);
    logic [CALC_W-1:0] r;
    if (a >= b) begin
      r = a - b;
    end else begin
      r = a + CALC_W'(m) - b;
    end
    return r;
  endfunction

  assign in_ready = (state == IDLE);

  // in_mod_1 spans exactly 0..31, so it can never be out of range.
  assign err_in = (in_mod_2 > MAX_MOD'(30)) ||
                  (in_mod_3 > MAX_MOD'(20)) ||
                  (in_mod_4 > MAX_MOD'(4));

  always_comb begin
    part1 = CALC_W'(v1) + (CALC_W'(v2) << 5);
    part2 = part1 + CALC_W'(v3) * CALC_W'(992);
    total = part2 + CALC_W'(v4) * CALC_W'(20832);

    // 32 = 1 (mod 31): the digit is the plain difference.
    v2_next = 5'(mod_sub(CALC_W'(x2), mod_reduce(CALC_W'(v1), 6'd31), 6'd31));
    // 17 is the inverse of 992 (= 5) mod 21.
    v3_next = 5'(mod_reduce(mod_sub(CALC_W'(x3), mod_reduce(part1, 6'd21), 6'd21)
                            * CALC_W'(17), 6'd21));
    // 3 is the inverse of 20832 (= 2) mod 5.
    v4_next = 3'(mod_reduce(mod_sub(CALC_W'(x4), mod_reduce(part2, 6'd5), 6'd5)
                            * CALC_W'(3), 6'd5));

    bin_next = (DYN_SIZE+1)'(total);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      x2        <= '0;
      x3        <= '0;
      x4        <= '0;
      v1        <= '0;
      v2        <= '0;
      v3        <= '0;
      v4        <= '0;
      err_flag  <= 1'b0;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x2       <= in_mod_2;
            x3       <= in_mod_3;
            x4       <= in_mod_4;
            v1       <= in_mod_1;
            err_flag <= err_in;
            state    <= V2;
          end
        end
        V2: begin
          v2    <= v2_next;
          state <= V3;
        end
        V3: begin
          v3    <= v3_next;
          state <= V4;
        end
        V4: begin
          v4    <= v4_next;
          state <= SUM;
        end
        SUM: begin
          // An invalid tuple still walks the full pipeline so latency and
          // handshake are identical; only the data is forced to zero.
          out_bin   <= err_flag ? '0 : bin_next;
          out_err   <= err_flag;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
